ctr_mode_ctrl: RTL and testbench
================================

Name: ctr_mode_ctrl

Overview:
- CTR-mode front end for the AES-256 encryption core; sits directly upstream of the core and consumes its output.
- Builds counter blocks (nonce || counter) and hands each one to the core through a start/done handshake.
- XORs the returned keystream with the buffered data block and presents the ciphertext (or plaintext) on a valid/ready output.
- One block in flight at a time; the 32-bit counter increments once per completed block.

Parameters:
- NONCE_W, 96, nonce width in bits; occupies block bits [127:32].
- CTR_W, 32, counter width in bits; occupies block bits [31:0]. NONCE_W + CTR_W must equal 128.
- TIMEOUT_CYC, 64, maximum cycles to wait for core_done before aborting the block.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- load  in  1  one-cycle pulse that captures load_nonce and load_ctr.
- load_nonce  in  96  nonce value.
- load_ctr  in  32  initial counter value.
- in_valid  in  1  input data block valid.
- in_ready  out  1  block can accept a data block.
- in_data  in  128  plaintext or ciphertext block.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  128  in_data XOR keystream.
- core_start  out  1  one-cycle request to the AES core.
- core_block  out  128  counter block sent to the core; held stable from start until done.
- core_done  in  1  one-cycle pulse from the core; core_keystream is valid in the same cycle.
- core_keystream  in  128  AES-256(key, core_block).
- busy  out  1  asserted in any state other than IDLE or READY.
- err  out  1  sticky timeout flag; cleared by load.

Behaviour:
- Reset values (rst=0, asynchronous): state IDLE; in_ready, out_valid, core_start, busy, err = 0; out_data, core_block, nonce and counter registers = 0.
- FSM states: IDLE, READY, REQ, WAIT, OUT.
- IDLE: in_ready=0. On load, capture nonce and counter, then go to READY.
- READY: in_ready=1. On in_valid and in_ready, capture in_data and go to REQ. A load in READY recaptures the nonce and counter.
- REQ: core_start=1 for exactly one cycle; core_block = {nonce, ctr}. Next state is WAIT.
- WAIT: a timeout counter increments each cycle.
  - On core_done: out_data <= data XOR core_keystream; ctr <= ctr+1 (mod 2^32); go to OUT.
  - If the timeout counter reaches TIMEOUT_CYC-1 without core_done: set err, leave ctr unchanged, drop the data, go to READY.
- OUT: out_valid=1 with out_data held stable. On out_ready, go to READY. out_ready while out_valid=0 is ignored.
- load is ignored in REQ, WAIT and OUT (the block is busy); err is not set.
- A core_done arriving in any state other than WAIT is ignored.
- Latency:
  - Input handshake at cycle T gives core_start at T+1.
  - core_done at cycle D gives out_valid at D+1.
  - Earliest next in_ready is the cycle after the out handshake.
- Counter wrap: 0xFFFFFFFF increments to 0x00000000 silently unless CTR_WRAP_ERR_EN is defined.
- Reset mid-operation returns to IDLE and discards all state. A subsequent core_done is ignored until a new block reaches WAIT.

Optional Feature:
- Macro: CTR_WRAP_ERR_EN.
- Defined: when a block completes with ctr==0xFFFFFFFF, the output is still delivered and err is set. Afterwards the FSM returns to IDLE instead of READY and requires a new load, which prevents keystream reuse.
- Undefined: the counter wraps silently and err is set only by timeout.

Decomposition:
- Shared package ctr_pkg holds:
  - the state enum (IDLE, READY, REQ, WAIT, OUT);
  - BLOCK_W=128, NONCE_W, CTR_W;
  - the counter-block concatenation function.
- One natural sub-module: ctr_timeout_cnt, a loadable down-counter with an expire flag, used in WAIT.
- The XOR and the FSM stay in the top level.

Test Plan:
- Single block. Bench core model returns ~core_block after 14 cycles.
  - Stimulus: load nonce=0xF0F1F2F3F4F5F6F7F8F9FAFB, ctr=0xFCFDFEFF; in_data=0x6BC1BEE22E409F96E93D7E117393172A.
  - Required: core_block = 0xF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF; out_data = in_data ^ ~core_block; next core_block ends in 0xFCFDFF00.
- Backpressure: hold out_ready=0 for 10 cycles. out_data stays stable, in_ready=0 throughout, and there is no second core_start.
- Timeout: the core model never responds. err=1 at cycle TIMEOUT_CYC after WAIT entry, the FSM returns to READY, and ctr is unchanged.
- Wrap: ctr=0xFFFFFFFF, two blocks.
  - Without CTR_WRAP_ERR_EN: the second core_block ends in 0x00000000 and err stays 0.
  - With CTR_WRAP_ERR_EN: err=1 after the first block, the FSM goes to IDLE, and in_ready=0 until load.
- Reset mid-WAIT: drive rst=0 for 1 cycle. All outputs return to 0 and the FSM is in IDLE. A late core_done produces no out_valid.
- load while busy: pulse load in WAIT with a different nonce. The current core_block is unchanged and the next block still uses the old nonce.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared definitions for the CTR-mode front end.
// Holds the FSM state encoding, the block geometry and the counter-block packing helper.
package ctr_pkg;

    localparam int BLOCK_W = 128;
    localparam int NONCE_W = 96;
    localparam int CTR_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        REQ,
        WAIT,
        OUT
    } state_t;

    // Nonce sits in the upper bits and the counter in the low word.
    function automatic logic [BLOCK_W-1:0] ctr_block(input logic [NONCE_W-1:0] nonce,
                                                     input logic [CTR_W-1:0]   ctr);
        return {nonce, ctr};
    endfunction

endpackage

// File: rtl/ctr_mode_ctrl_if.sv
// Data-in, result-out and AES-core handshake bundle for ctr_mode_ctrl.
// The master modport is the controller; the slave modport is the environment (source, sink, core).
interface ctr_mode_ctrl_if;
    import ctr_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               core_start;
    logic [BLOCK_W-1:0] core_block;
    logic               core_done;
    logic [BLOCK_W-1:0] core_keystream;

    modport master (
        input  in_valid, in_data, out_ready, core_done, core_keystream,
        output in_ready, out_valid, out_data, core_start, core_block
    );

    modport slave (
        output in_valid, in_data, out_ready, core_done, core_keystream,
        input  in_ready, out_valid, out_data, core_start, core_block
    );

endinterface

// File: rtl/ctr_timeout_cnt.sv
// Loadable down-counter guarding the wait for the AES core; expired is high once the count reaches zero.
// Loaded one cycle before the wait starts, so expiry lands TIMEOUT_CYC-1 cycles into the wait; no backpressure.
module ctr_timeout_cnt #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(TIMEOUT_CYC - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/ctr_mode_ctrl.sv
// CTR-mode front end: sends {nonce, ctr} to the AES core, XORs the keystream into the buffered block; one block in flight.
// core_start at T+1 after input accept, out_valid at D+1 after core_done, in_ready held low until the result is taken; CTR_WRAP_ERR_EN flags counter wrap.
module ctr_mode_ctrl
    import ctr_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [NONCE_W-1:0] load_nonce,
    input  logic [CTR_W-1:0]   load_ctr,
    ctr_mode_ctrl_if.master    bus,
    output logic               busy,
    output logic               err
);

    state_t             state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic [BLOCK_W-1:0] out_data_q, out_data_d;
    logic [BLOCK_W-1:0] core_block_q, core_block_d;
    logic               err_q, err_d;
    logic               tmo_load, tmo_en, tmo_expired;
`ifdef CTR_WRAP_ERR_EN
    logic               wrap_q, wrap_d;
`endif

    ctr_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .load    (tmo_load),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    assign tmo_load = (state_q == REQ);
    assign tmo_en   = (state_q == WAIT);

    always_comb begin
        state_d      = state_q;
        nonce_d      = nonce_q;
        ctr_d        = ctr_q;
        data_d       = data_q;
        out_data_d   = out_data_q;
        core_block_d = core_block_q;
        err_d        = err_q;
`ifdef CTR_WRAP_ERR_EN
        wrap_d       = wrap_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    nonce_d = load_nonce;
                    ctr_d   = load_ctr;
                    err_d   = 1'b0;
                    state_d = READY;
                end
            end
            READY: begin
                if (load) begin
                    nonce_d = load_nonce;
                    ctr_d   = load_ctr;
                    err_d   = 1'b0;
                end
                if (bus.in_valid) begin
                    data_d       = bus.in_data;
                    core_block_d = ctr_block(nonce_q, ctr_q);
                    state_d      = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A done in the expiry cycle still counts as a completed block.
                if (bus.core_done) begin
                    out_data_d = data_q ^ bus.core_keystream;
                    ctr_d      = ctr_q + 1'b1;
                    state_d    = OUT;
`ifdef CTR_WRAP_ERR_EN
                    if (ctr_q == '1) begin
                        err_d  = 1'b1;
                        wrap_d = 1'b1;
                    end
`endif
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = READY;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
`ifdef CTR_WRAP_ERR_EN
                    state_d = wrap_q ? IDLE : READY;
                    wrap_d  = 1'b0;
`else
                    state_d = READY;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            nonce_q      <= '0;
            ctr_q        <= '0;
            data_q       <= '0;
            out_data_q   <= '0;
            core_block_q <= '0;
            err_q        <= 1'b0;
`ifdef CTR_WRAP_ERR_EN
            wrap_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            nonce_q      <= nonce_d;
            ctr_q        <= ctr_d;
            data_q       <= data_d;
            out_data_q   <= out_data_d;
            core_block_q <= core_block_d;
            err_q        <= err_d;
`ifdef CTR_WRAP_ERR_EN
            wrap_q       <= wrap_d;
`endif
        end
    end

    assign bus.in_ready   = (state_q == READY);
    assign bus.core_start = (state_q == REQ);
    assign bus.out_valid  = (state_q == OUT);
    assign bus.out_data   = out_data_q;
    assign bus.core_block = core_block_q;
    assign busy           = (state_q != IDLE) && (state_q != READY);
    assign err            = err_q;

endmodule

// File: tb/tb_ctr_mode_ctrl.sv
// Self-checking bench for ctr_mode_ctrl: directed vector table, multi-cycle corner sequences and randomized blocks
// checked against a nonce/counter reference model; the core model answers ~core_block after a chosen delay.
module tb_ctr_mode_ctrl;
    import ctr_pkg::*;

    localparam int TMO = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               load = 1'b0;
    logic [NONCE_W-1:0] load_nonce = '0;
    logic [CTR_W-1:0]   load_ctr = '0;
    logic               busy, err;

    int errors = 0;
    int checks = 0;

    logic [95:0] m_nonce = '0;
    logic [31:0] m_ctr = '0;

    typedef struct {
        bit           do_ld;
        logic [95:0]  nonce;
        logic [31:0]  ctr;
        logic [127:0] data;
        logic [127:0] exp_blk;
        logic [127:0] exp_out;
    } vec_t;

    vec_t vt [4];

    ctr_mode_ctrl_if bus ();

    ctr_mode_ctrl #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_nonce (load_nonce),
        .load_ctr   (load_ctr),
        .bus        (bus),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [95:0] n, input logic [31:0] c);
        load = 1'b1;
        load_nonce = n;
        load_ctr = c;
        @(negedge clk);
        load = 1'b0;
        m_nonce = n;
        m_ctr = c;
    endtask

    // Entered at a negedge in READY; returns at the negedge where the request is presented.
    task automatic start_block(input string tag, input logic [127:0] d, input logic [127:0] exp_blk);
        chk({tag, ".in_ready"}, bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        chk({tag, ".core_start"}, bus.core_start, 1'b1);
        chk({tag, ".core_block"}, bus.core_block, exp_blk);
        chk({tag, ".busy"}, busy, 1'b1);
    endtask

    // Core model replies after dly cycles, then the sink stalls for hold cycles before accepting.
    task automatic finish_block(input string tag, input logic [127:0] exp_blk,
                                input logic [127:0] exp_out, input int dly, input int hold);
        int extra_starts = 0;
        int bad = 0;
        logic [127:0] held;
        repeat (dly) begin
            @(negedge clk);
            if (bus.core_start) extra_starts++;
            if (bus.core_block !== exp_blk) bad++;
        end
        bus.core_done = 1'b1;
        bus.core_keystream = ~bus.core_block;
        @(negedge clk);
        bus.core_done = 1'b0;
        bus.core_keystream = '0;
        chk({tag, ".out_valid"}, bus.out_valid, 1'b1);
        chk({tag, ".out_data"}, bus.out_data, exp_out);
        held = bus.out_data;
        repeat (hold) begin
            @(negedge clk);
            if (bus.out_data !== held || bus.in_ready || !bus.out_valid) bad++;
            if (bus.core_start) extra_starts++;
        end
        chk({tag, ".stable"}, bad, 0);
        chk({tag, ".one_start"}, extra_starts, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [127:0] d, input int dly, input int hold);
        logic [127:0] exp_blk;
        exp_blk = {m_nonce, m_ctr};
        start_block(tag, d, exp_blk);
        finish_block(tag, exp_blk, d ^ ~exp_blk, dly, hold);
        m_ctr = m_ctr + 32'd1;
    endtask

    initial begin
        logic [127:0] blk;
        logic [127:0] d;
        int bad;

        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus.core_done = 1'b0;
        bus.core_keystream = '0;

        vt[0] = '{1'b1, 96'hF0F1F2F3F4F5F6F7F8F9FAFB, 32'hFCFDFEFF,
                  128'h6BC1BEE22E409F96E93D7E117393172A,
                  128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF,
                  128'h64CFB3EE254A969EEE3B7B157091162A};
        vt[1] = '{1'b0, '0, '0, 128'hAE2D8A571E03AC9C9EB76FAC45AF8E51,
                  128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFF00, '0};
        vt[1].exp_out = vt[1].data ^ ~vt[1].exp_blk;
        vt[2] = '{1'b1, 96'h0, 32'h0, {128{1'b1}}, 128'h0, 128'h0};
        vt[3] = '{1'b1, {96{1'b1}}, 32'h12345678, 128'h0,
                  {{96{1'b1}}, 32'h12345678}, {96'h0, 32'hEDCBA987}};

        // Reset state
        @(negedge clk);
        chk("rst.in_ready", bus.in_ready, 1'b0);
        chk("rst.out_valid", bus.out_valid, 1'b0);
        chk("rst.core_start", bus.core_start, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.err", err, 1'b0);
        chk("rst.out_data", bus.out_data, '0);
        chk("rst.core_block", bus.core_block, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle.in_ready", bus.in_ready, 1'b0);

        // Directed vector table
        for (int i = 0; i < 4; i++) begin
            if (vt[i].do_ld) begin
                do_load(vt[i].nonce, vt[i].ctr);
                chk($sformatf("vec%0d.ready_after_load", i), bus.in_ready, 1'b1);
            end
            start_block($sformatf("vec%0d", i), vt[i].data, vt[i].exp_blk);
            finish_block($sformatf("vec%0d", i), vt[i].exp_blk, vt[i].exp_out, 14, 0);
            m_ctr = m_ctr + 32'd1;
            chk($sformatf("vec%0d.ready_next", i), bus.in_ready, 1'b1);
        end

        // Stray core_done outside WAIT is ignored
        bus.core_done = 1'b1;
        bus.core_keystream = {4{32'hDEADBEEF}};
        @(negedge clk);
        bus.core_done = 1'b0;
        chk("stray_done.out_valid", bus.out_valid, 1'b0);
        chk("stray_done.in_ready", bus.in_ready, 1'b1);

        // Backpressure: ten stalled cycles on the output
        run_block("bp", {$urandom, $urandom, $urandom, $urandom}, 6, 10);

        // load while busy must not disturb the block in flight or the next one
        do_load(96'h0123456789ABCDEF01234567, 32'h00000100);
        blk = {m_nonce, m_ctr};
        d = {$urandom, $urandom, $urandom, $urandom};
        start_block("ldbusy", d, blk);
        @(negedge clk);
        load = 1'b1;
        load_nonce = 96'hFEDCBA9876543210FEDCBA98;
        load_ctr = 32'h55555555;
        @(negedge clk);
        load = 1'b0;
        chk("ldbusy.core_block", bus.core_block, blk);
        finish_block("ldbusy", blk, d ^ ~blk, 5, 0);
        m_ctr = m_ctr + 32'd1;
        chk("ldbusy.err", err, 1'b0);
        run_block("ldbusy_next", {$urandom, $urandom, $urandom, $urandom}, 3, 0);

        // Timeout: core never answers
        blk = {m_nonce, m_ctr};
        start_block("tmo", {$urandom, $urandom, $urandom, $urandom}, blk);
        @(negedge clk);
        repeat (TMO - 1) @(negedge clk);
        chk("tmo.err_before", err, 1'b0);
        chk("tmo.busy_before", busy, 1'b1);
        @(negedge clk);
        chk("tmo.err", err, 1'b1);
        chk("tmo.in_ready", bus.in_ready, 1'b1);
        chk("tmo.out_valid", bus.out_valid, 1'b0);
        chk("tmo.busy", busy, 1'b0);
        run_block("tmo_next", {$urandom, $urandom, $urandom, $urandom}, 2, 1);
        chk("tmo.err_sticky", err, 1'b1);

        // Reset in the middle of WAIT
        start_block("rstw", {$urandom, $urandom, $urandom, $urandom}, {m_nonce, m_ctr});
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstw.in_ready", bus.in_ready, 1'b0);
        chk("rstw.out_valid", bus.out_valid, 1'b0);
        chk("rstw.core_start", bus.core_start, 1'b0);
        chk("rstw.busy", busy, 1'b0);
        chk("rstw.err", err, 1'b0);
        chk("rstw.out_data", bus.out_data, '0);
        chk("rstw.core_block", bus.core_block, '0);
        @(negedge clk);
        rst = 1'b1;
        bus.core_done = 1'b1;
        bus.core_keystream = {4{32'hA5A5A5A5}};
        @(negedge clk);
        bus.core_done = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid || bus.in_ready || busy) bad++;
        end
        chk("rstw.late_done", bad, 0);

        // Counter wrap
        do_load(96'hCAFEF00DCAFEF00DCAFEF00D, 32'hFFFFFFFF);
        run_block("wrap1", {$urandom, $urandom, $urandom, $urandom}, 4, 0);
`ifdef CTR_WRAP_ERR_EN
        chk("wrap.err", err, 1'b1);
        chk("wrap.in_ready", bus.in_ready, 1'b0);
        chk("wrap.busy", busy, 1'b0);
        bus.in_valid = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.in_ready || bus.core_start) bad++;
        end
        bus.in_valid = 1'b0;
        chk("wrap.locked", bad, 0);
        do_load(m_nonce, m_ctr);
        chk("wrap.err_cleared", err, 1'b0);
`else
        chk("wrap.err", err, 1'b0);
        chk("wrap.in_ready", bus.in_ready, 1'b1);
`endif
        run_block("wrap2", {$urandom, $urandom, $urandom, $urandom}, 4, 0);
        chk("wrap2.err", err, 1'b0);

        // Randomized blocks against the reference model
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_load({$urandom, $urandom, $urandom}, $urandom & 32'h7FFFFFFF);
            end
            run_block($sformatf("rnd%0d", i), {$urandom, $urandom, $urandom, $urandom},
                      $urandom_range(1, 20), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
